// File: rtl/turn_controller_pkg.sv
// turn_controller_pkg: board dimensions, turn FSM states and winner codes shared by the turn sequencer
package turn_controller_pkg;
  localparam int C4_COLS = 7;
  localparam int C4_ROWS = 6;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_MOVE, DROP, CHECK, DONE} turn_state_t;
  typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10, WIN_DRAW = 2'b11} winner_t;
  function automatic winner_t player_win(input logic p);
    return p ? WIN_P2 : WIN_P1;
  endfunction
endpackage

// File: rtl/turn_controller_if.sv
// turn_controller_if: player/timer/checker inputs and timer/drop/result outputs of the turn sequencer
interface turn_controller_if import turn_controller_pkg::*; #(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  logic            start;
  logic            move_valid;
  logic [CW-1:0]   move_col;
  logic            timer_expired;
  logic            check_done;
  logic            check_win;
  logic            timer_reset;
  logic            timer_enable;
  logic            cur_player;
  logic            drop_valid;
  logic [CW-1:0]   drop_col;
  logic [RW-1:0]   drop_row;
  logic            auto_move;
  logic            illegal_move;
  logic [COLS-1:0] col_full;
  logic            done;
  logic [1:0]      winner;
  modport master (
    output start, move_valid, move_col, timer_expired, check_done, check_win,
    input  timer_reset, timer_enable, cur_player, drop_valid, drop_col, drop_row,
           auto_move, illegal_move, col_full, done, winner
  );
  modport slave (
    input  start, move_valid, move_col, timer_expired, check_done, check_win,
    output timer_reset, timer_enable, cur_player, drop_valid, drop_col, drop_row,
           auto_move, illegal_move, col_full, done, winner
  );
endinterface

// File: rtl/turn_controller_column_heights.sv
// column_heights: saturating per-column fill counters with full flags, board-full flag and lowest free column
module column_heights #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int CW = $clog2(COLS),
  parameter int RW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic            i_inc,
  input  logic [CW-1:0]   i_col,
  output logic [RW-1:0]   o_height,
  output logic [COLS-1:0] o_col_full,
  output logic            o_all_full,
  output logic [CW-1:0]   o_first_free
);
  localparam int HW = $clog2(ROWS + 1);
  localparam logic [HW-1:0] FULL = HW'(ROWS);
  localparam logic [CW-1:0] LAST = CW'(COLS - 1);
  logic [HW-1:0] r_height [COLS];
  for (genvar c = 0; c < COLS; c++) begin : g_col
    always_ff @(posedge clk) begin
      if (reset || i_clr) r_height[c] <= '0;
      else if (i_inc && i_col == CW'(c) && r_height[c] != FULL) r_height[c] <= r_height[c] + 1'b1;
    end
    assign o_col_full[c] = r_height[c] == FULL;
  end
  assign o_all_full = &o_col_full;
  assign o_height = (i_col <= LAST) ? RW'(r_height[i_col]) : '0;
  always_comb begin
    o_first_free = '0;
    for (int i = COLS - 1; i >= 0; i--) if (!o_col_full[i]) o_first_free = CW'(i);
  end
endmodule

// File: rtl/turn_controller.sv
// turn_controller: Connect-4 turn sequencer driving the move timer, one drop per turn and the game result
module turn_controller import turn_controller_pkg::*; #(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
) (
  input logic clk,
  input logic reset,
  turn_controller_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int FW = 1 << CW;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  turn_state_t r_state, w_next;
  logic [CW-1:0] r_col, w_col, w_first_free, r_drop_col;
  logic [RW-1:0] w_height, r_drop_row;
  logic [1:0] r_winner, w_winner;
  logic [COLS-1:0] w_col_full;
  logic [FW-1:0] w_full_ext;
  logic r_auto, w_auto, r_player, w_player, w_clr, w_all_full, w_legal, w_illegal;
  logic r_timer_reset, r_timer_enable, r_drop_valid, r_auto_move, r_illegal, r_done;
  column_heights #(.COLS(COLS), .ROWS(ROWS)) u_heights (
    .clk(clk),
    .reset(reset),
    .i_clr(w_clr),
    .i_inc(r_state == DROP),
    .i_col(w_col),
    .o_height(w_height),
    .o_col_full(w_col_full),
    .o_all_full(w_all_full),
    .o_first_free(w_first_free)
  );
  assign w_full_ext = FW'(w_col_full);
  assign w_legal = bus.move_valid && bus.move_col <= LAST_COL && !w_full_ext[bus.move_col];
  assign w_illegal = bus.move_valid && !w_legal;
  always_comb begin
    w_next = r_state;
    w_col = r_col;
    w_auto = r_auto;
    w_player = r_player;
    w_winner = r_winner;
    w_clr = 1'b0;
    case (r_state)
      IDLE, DONE: if (bus.start) begin
        w_next = ARM;
        w_clr = 1'b1;
        w_player = 1'b0;
        w_winner = WIN_NONE;
      end
      ARM: w_next = WAIT_MOVE;
      WAIT_MOVE: if (w_legal || bus.timer_expired) begin
        w_next = DROP;
        w_col = w_legal ? bus.move_col : w_first_free;
        w_auto = !w_legal;
      end
      DROP: w_next = CHECK;
      CHECK: if (bus.check_done) begin
        w_next = (bus.check_win || w_all_full) ? DONE : ARM;
        w_winner = bus.check_win ? player_win(r_player) : w_all_full ? WIN_DRAW : WIN_NONE;
        w_player = (bus.check_win || w_all_full) ? r_player : !r_player;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_col <= '0;
      r_auto <= 1'b0;
      r_player <= 1'b0;
      r_winner <= WIN_NONE;
      r_timer_reset <= 1'b0;
      r_timer_enable <= 1'b0;
      r_drop_valid <= 1'b0;
      r_drop_col <= '0;
      r_drop_row <= '0;
      r_auto_move <= 1'b0;
      r_illegal <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_col <= w_col;
      r_auto <= w_auto;
      r_player <= w_player;
      r_winner <= w_winner;
      r_timer_reset <= w_next == ARM;
      r_timer_enable <= w_next == WAIT_MOVE;
      r_drop_valid <= w_next == DROP;
      r_drop_col <= (w_next == DROP) ? w_col : '0;
      r_drop_row <= (w_next == DROP) ? w_height : '0;
      r_auto_move <= w_next == DROP && w_auto;
      r_illegal <= r_state == WAIT_MOVE && w_illegal;
      r_done <= w_next == DONE;
    end
  end
  assign bus.timer_reset = r_timer_reset;
  assign bus.timer_enable = r_timer_enable;
  assign bus.cur_player = r_player;
  assign bus.drop_valid = r_drop_valid;
  assign bus.drop_col = r_drop_col;
  assign bus.drop_row = r_drop_row;
  assign bus.auto_move = r_auto_move;
  assign bus.illegal_move = r_illegal;
  assign bus.col_full = w_col_full;
  assign bus.done = r_done;
  assign bus.winner = r_winner;
endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: table-driven and sequence checks of the Connect-4 turn sequencer
module tb_turn_controller;
  import turn_controller_pkg::*;
  typedef struct packed {
    logic tr, te, cp, dv;
    logic [2:0] dc, dr;
    logic am, il, dn;
    logic [1:0] w;
  } outs_t;
  typedef struct packed {
    logic s, mv;
    logic [2:0] c;
    logic t, cd, cw;
    outs_t e;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int h[7];
  logic p;
  vec_t tv[17];
  always #5 clk = ~clk;
  turn_controller_if bus ();
  turn_controller dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic outs_t outs();
    return {bus.timer_reset, bus.timer_enable, bus.cur_player, bus.drop_valid, bus.drop_col,
            bus.drop_row, bus.auto_move, bus.illegal_move, bus.done, bus.winner};
  endfunction
  function automatic vec_t v(input logic s, mv, input logic [2:0] c, input logic t, cd, cw,
                             input logic tr, te, cp, dv, input logic [2:0] dc, dr,
                             input logic am, il, dn, input logic [1:0] w);
    return {s, mv, c, t, cd, cw, tr, te, cp, dv, dc, dr, am, il, dn, w};
  endfunction
  function automatic logic [2:0] first_free();
    for (int i = 0; i < 7; i++) if (h[i] < 6) return 3'(i);
    return 3'd0;
  endfunction
  function automatic logic board_full();
    for (int i = 0; i < 7; i++) if (h[i] < 6) return 1'b0;
    return 1'b1;
  endfunction
  task automatic idle_in();
    bus.start = 0;
    bus.move_valid = 0;
    bus.move_col = 0;
    bus.timer_expired = 0;
    bus.check_done = 0;
    bus.check_win = 0;
  endtask
  task automatic wait_en();
    int k = 0;
    while (!bus.timer_enable && k < 20) begin
      tick();
      k++;
    end
    chk("wait_move_reached", 32'(bus.timer_enable), 32'd1);
  endtask
  task automatic do_start();
    bus.start = 1;
    tick();
    bus.start = 0;
    p = 0;
    foreach (h[i]) h[i] = 0;
    chk("start_timer_reset", 32'(bus.timer_reset), 32'd1);
    chk("start_done", 32'(bus.done), 32'd0);
    chk("start_winner", 32'(bus.winner), 32'd0);
    chk("start_player", 32'(bus.cur_player), 32'd0);
    chk("start_col_full", 32'(bus.col_full), 32'd0);
  endtask
  task automatic turn(input logic [2:0] col, input logic mv, input logic tmo, input logic win);
    logic [2:0] ec;
    logic [1:0] ew;
    wait_en();
    ec = mv ? col : first_free();
    bus.move_valid = mv;
    bus.move_col = col;
    bus.timer_expired = tmo;
    tick();
    idle_in();
    chk("drop_valid", 32'(bus.drop_valid), 32'd1);
    chk("drop_col", 32'(bus.drop_col), 32'(ec));
    chk("drop_row", 32'(bus.drop_row), 32'(h[ec]));
    chk("auto_move", 32'(bus.auto_move), 32'(!mv));
    chk("drop_player", 32'(bus.cur_player), 32'(p));
    h[ec]++;
    tick();
    bus.check_done = 1;
    bus.check_win = win;
    tick();
    idle_in();
    ew = win ? (p ? 2'b10 : 2'b01) : 2'b11;
    if (win || board_full()) begin
      chk("end_done", 32'(bus.done), 32'd1);
      chk("end_winner", 32'(bus.winner), 32'(ew));
    end else begin
      chk("next_player", 32'(bus.cur_player), 32'(!p));
      chk("next_arm", 32'(bus.timer_reset), 32'd1);
      p = !p;
    end
  endtask
  initial begin
    idle_in();
    tv[0]  = v(1,0,0,0,0,0, 1,0,0,0,0,0,0,0,0,0);
    tv[1]  = v(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    tv[2]  = v(0,1,3,0,0,0, 0,0,0,1,3,0,0,0,0,0);
    tv[3]  = v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
    tv[4]  = v(0,0,0,0,1,0, 1,0,1,0,0,0,0,0,0,0);
    tv[5]  = v(0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0,0);
    tv[6]  = v(1,1,7,0,0,0, 0,1,1,0,0,0,0,1,0,0);
    tv[7]  = v(0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0,0);
    tv[8]  = v(0,0,0,1,0,0, 0,0,1,1,0,0,1,0,0,0);
    tv[9]  = v(1,0,0,0,0,0, 0,0,1,0,0,0,0,0,0,0);
    tv[10] = v(0,0,0,0,0,1, 0,0,1,0,0,0,0,0,0,0);
    tv[11] = v(0,0,0,0,1,0, 1,0,0,0,0,0,0,0,0,0);
    tv[12] = v(0,0,0,0,0,0, 0,1,0,0,0,0,0,0,0,0);
    tv[13] = v(0,1,3,1,0,0, 0,0,0,1,3,1,0,0,0,0);
    tv[14] = v(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
    tv[15] = v(0,0,0,0,1,1, 0,0,0,0,0,0,0,0,1,1);
    tv[16] = v(0,1,2,1,0,0, 0,0,0,0,0,0,0,0,1,1);
    repeat (3) tick();
    chk("reset_outputs", 32'(outs()), 32'd0);
    chk("reset_col_full", 32'(bus.col_full), 32'd0);
    reset = 0;
    tick();
    chk("idle_outputs", 32'(outs()), 32'd0);
    for (int i = 0; i < 17; i++) begin
      bus.start = tv[i].s;
      bus.move_valid = tv[i].mv;
      bus.move_col = tv[i].c;
      bus.timer_expired = tv[i].t;
      bus.check_done = tv[i].cd;
      bus.check_win = tv[i].cw;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tv[i].e));
    end
    idle_in();
    do_start();
    repeat (6) turn(3'd0, 1, 0, 0);
    wait_en();
    bus.move_valid = 1;
    bus.move_col = 0;
    tick();
    idle_in();
    chk("illegal_pulse", 32'(bus.illegal_move), 32'd1);
    chk("illegal_no_drop", 32'(bus.drop_valid), 32'd0);
    chk("illegal_timer_on", 32'(bus.timer_enable), 32'd1);
    tick();
    chk("illegal_cleared", 32'(bus.illegal_move), 32'd0);
    chk("illegal_still_wait", 32'(bus.timer_enable), 32'd1);
    repeat (6) turn(3'd1, 1, 0, 0);
    chk("col_full_01", 32'(bus.col_full), 32'h03);
    turn(3'd0, 0, 1, 0);
    turn(3'd4, 1, 1, 0);
    turn(3'd5, 1, 0, 0);
    turn(3'd5, 1, 0, 1);
    bus.move_valid = 1;
    bus.move_col = 6;
    tick();
    idle_in();
    chk("done_ignore_drop", 32'(bus.drop_valid), 32'd0);
    chk("done_hold", 32'(bus.done), 32'd1);
    chk("done_winner_p2", 32'(bus.winner), 32'h2);
    chk("done_timer_off", 32'(bus.timer_enable), 32'd0);
    do_start();
    for (int n = 0; n < 42; n++) turn(3'(n / 6), 1, 0, 0);
    do_start();
    for (int n = 0; n < 42; n++) turn(3'(n / 6), 1, 0, n == 41);
    do_start();
    repeat (6) turn(3'd2, 1, 0, 0);
    chk("col_full_2", 32'(bus.col_full), 32'h04);
    wait_en();
    bus.move_valid = 1;
    bus.move_col = 3;
    tick();
    idle_in();
    chk("pre_reset_drop_row", 32'(bus.drop_row), 32'd0);
    tick();
    reset = 1;
    tick();
    reset = 0;
    chk("check_reset_outputs", 32'(outs()), 32'd0);
    chk("check_reset_col_full", 32'(bus.col_full), 32'd0);
    tick();
    chk("post_reset_idle", 32'(outs()), 32'd0);
    do_start();
    wait_en();
    bus.move_valid = 1;
    bus.move_col = 2;
    tick();
    idle_in();
    chk("post_reset_drop_col", 32'(bus.drop_col), 32'd2);
    chk("post_reset_drop_row", 32'(bus.drop_row), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
